calc_ctrl_unit_p: RTL and testbench
===================================

# calc_ctrl_unit_p

Parametrised next-generation control unit for the calculator system datapath. It sequences operand load, ALU, multiplier and divider operations, and result-register writes from a 3-bit op code. Unlike the previous unit, it latches the op code, applies the divide-by-zero check to divides only, and waits a configurable number of cycles for the multiplier. It also bounds every wait for a done handshake with a timeout and reports a coded, sticky error.

## Interface
- MUL_LAT, default 3: cycles spent in MWAIT for the multiplier result; legal range ≥1.
- TIMEOUT, default 64: maximum cycles in CWAIT/DWAIT before the timeout error; legal range ≥2.
- TW, default $clog2(TIMEOUT+1): internal timer width; derived, not overridden.
- clk  in  1  clock. One clock domain; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- go  in  1  start request; sampled in IDLE only.
- op_code  in  3  operation: 0-3 ALU (op_calc=op[1:0]), 4 DIV, 5 MUL, 6 pass A, 7 pass B.
- y_zero  in  1  divisor-is-zero flag from the datapath.
- done_calc  in  1  ALU completion.
- done_div  in  1  divider completion.
- x_en, y_en, f_en  out  1 each  operand and flag register loads.
- hi_en, lo_en  out  1 each  result register writes.
- sel_hi, sel_lo  out  2 each  result source: 00 pass, 01 ALU, 10 MUL, 11 DIV.
- op_calc  out  2  ALU function.
- sel_p  out  1  pass select: 0 = A, 1 = B.
- go_calc, go_div  out  1 each  unit start/hold.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  2  00 none, 01 divide-by-zero, 10 timeout; sticky.
- cs  out  4  current state, for debug.

## Operation
- States: IDLE=0, LOAD=1, DECODE=2, CGO=3, MWAIT=4, DIVGO=5, CWAIT=6, DWAIT=7, DONE=8, ERR=9. Codes 10-15 return to IDLE on the next edge.
- Outputs are Moore: decoded from cs and the latched op_q only. Any output not listed for a state is 0.
- IDLE:
  - go=1 → LOAD; op_q ← op_code; err ← 00.
  - go=0 → stay.
  - y_zero does not block entry.
- LOAD: x_en=y_en=f_en=1 → DECODE.
- DECODE: sel_p=op_q[0] when op_q∈{6,7}. Transitions on op_q:
  - 0-3 → CGO.
  - 5 → MWAIT.
  - 6/7 → DONE.
  - 4 → ERR if y_zero=1 (err←01), else DIVGO.
- CGO: go_calc=1, op_calc=op_q[1:0], sel_lo=01 → CWAIT; timer←0.
- CWAIT: go_calc=1, op_calc=op_q[1:0], sel_hi=sel_lo=01.
  - done_calc → DONE.
  - Else if timer==TIMEOUT-1 → ERR, err←10.
  - Else timer++.
- MWAIT: sel_hi=sel_lo=10; timer++. Exit to DONE when timer==MUL_LAT-1 (timer←0 on entry).
- DIVGO: go_div=1, sel_lo=11 → DWAIT; timer←0.
- DWAIT: go_div=1, sel_hi=sel_lo=11. done_div and timeout handled as in CWAIT.
- DONE: hi_en=lo_en=1, done=1, sel_hi/sel_lo from the op_q class, sel_p=op_q[0] for pass ops → IDLE.
- ERR: hi_en=lo_en=0, done=0 → IDLE. err holds until the next accepted go or rst.

## Timing
- Reset: cs=IDLE, op_q=0, timer=0, err=00. Every output is 0 while rst is high and immediately on its assertion, mid-operation included.
- Latency from the go edge (cycle 0, in IDLE):
  - Pass: done in cycle 3.
  - MUL: done in cycle 3+MUL_LAT.
  - ALU: CWAIT from cycle 4; done_calc seen in cycle k gives done in k+1.
  - DIV: same as ALU with done_div.
  - Divide-by-zero: ERR in cycle 3.
- Timeout: at most TIMEOUT cycles in CWAIT/DWAIT. A done input in the final cycle wins over the timeout.
- op_code changes after acceptance have no effect. go while busy is ignored. go held high restarts directly after DONE/ERR returns to IDLE.

## Test plan
- Pass B: op=7, go pulse → done in cycle 3 with sel_p=1, hi_en=lo_en=1, sel_hi=sel_lo=00, err=00.
- ALU op=2, done_calc asserted 5 cycles after CWAIT entry → op_calc=10 throughout CGO/CWAIT, then done for one cycle; op_code toggled mid-run has no effect.
- MUL with MUL_LAT=3 and a second build with MUL_LAT=1: done in cycles 6 and 4 respectively.
- DIV with y_zero=1 → ERR, err=01, no hi_en; then op=0 with y_zero=1 completes normally and err clears to 00 on go.
- DIV with done_div never asserted, TIMEOUT=8 → 8 cycles in DWAIT, then ERR with err=10. Same run with done_div in the 8th DWAIT cycle → DONE.
- rst asserted in CWAIT → cs=0 and all outputs 0 asynchronously; a fresh go after release completes a pass op in 3 cycles.

Source files
------------

// File: rtl/calc_ctrl_unit_p.sv
// Sequencing controller for the calculator datapath: latches the op code on go,
// steps through load/decode/execute/write, and reports a sticky coded error.
//
// state  | meaning
// IDLE   | waiting for go, err holds
// LOAD   | load operand and flag registers
// DECODE | branch on latched op, divide-by-zero check
// CGO    | start ALU
// MWAIT  | fixed multiplier latency
// DIVGO  | start divider
// CWAIT  | wait for ALU done, bounded by timeout
// DWAIT  | wait for divider done, bounded by timeout
// DONE   | write result registers, completion pulse
// ERR    | abort without writing results
module calc_ctrl_unit_p #(
    parameter int MUL_LAT = 3,
    parameter int TIMEOUT = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_go,
    input  logic [2:0] i_op_code,
    input  logic       i_y_zero,
    input  logic       i_done_calc,
    input  logic       i_done_div,
    output logic       o_x_en,
    output logic       o_y_en,
    output logic       o_f_en,
    output logic       o_hi_en,
    output logic       o_lo_en,
    output logic [1:0] o_sel_hi,
    output logic [1:0] o_sel_lo,
    output logic [1:0] o_op_calc,
    output logic       o_sel_p,
    output logic       o_go_calc,
    output logic       o_go_div,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_err,
    output logic [3:0] o_cs
);

    // Timer is shared by the timeout waits and the multiplier wait.
    localparam int TMAX = (TIMEOUT > MUL_LAT) ? TIMEOUT : MUL_LAT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] MUL_LAST = TW'(MUL_LAT - 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LOAD   = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_CGO    = 4'd3;
    localparam logic [3:0] S_MWAIT  = 4'd4;
    localparam logic [3:0] S_DIVGO  = 4'd5;
    localparam logic [3:0] S_CWAIT  = 4'd6;
    localparam logic [3:0] S_DWAIT  = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;
    localparam logic [3:0] S_ERR    = 4'd9;

    logic [3:0]    r_cs;
    logic [3:0]    w_ns;
    logic [2:0]    r_op_q;
    logic [TW-1:0] r_timer;
    logic [1:0]    r_err;
    logic          w_tmo;
    logic          w_dz;
    logic [1:0]    w_cls;

    // A done input in the final wait cycle takes priority over the timeout.
    assign w_tmo = (r_timer == TO_LAST) &&
                   ((r_cs == S_CWAIT && !i_done_calc) || (r_cs == S_DWAIT && !i_done_div));
    assign w_dz  = (r_cs == S_DECODE) && (r_op_q == 3'd4) && i_y_zero;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_cs <= S_IDLE;
        else       r_cs <= w_ns;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op_q  <= '0;
            r_timer <= '0;
            r_err   <= 2'b00;
        end else begin
            if (r_cs == S_IDLE && i_go) begin
                r_op_q <= i_op_code;
                r_err  <= 2'b00;
            end else if (w_dz) begin
                r_err <= 2'b01;
            end else if (w_tmo) begin
                r_err <= 2'b10;
            end
            if (r_cs == S_CWAIT || r_cs == S_DWAIT || r_cs == S_MWAIT)
                r_timer <= r_timer + 1'b1;
            else
                r_timer <= '0;
        end
    end

    always_comb begin
        w_ns = S_IDLE;
        case (r_cs)
            S_IDLE:   w_ns = i_go ? S_LOAD : S_IDLE;
            S_LOAD:   w_ns = S_DECODE;
            S_DECODE: begin
                case (r_op_q)
                    3'd4:       w_ns = i_y_zero ? S_ERR : S_DIVGO;
                    3'd5:       w_ns = S_MWAIT;
                    3'd6, 3'd7: w_ns = S_DONE;
                    default:    w_ns = S_CGO;
                endcase
            end
            S_CGO:    w_ns = S_CWAIT;
            S_CWAIT:  w_ns = i_done_calc ? S_DONE : (w_tmo ? S_ERR : S_CWAIT);
            S_MWAIT:  w_ns = (r_timer == MUL_LAST) ? S_DONE : S_MWAIT;
            S_DIVGO:  w_ns = S_DWAIT;
            S_DWAIT:  w_ns = i_done_div ? S_DONE : (w_tmo ? S_ERR : S_DWAIT);
            S_DONE:   w_ns = S_IDLE;
            S_ERR:    w_ns = S_IDLE;
            default:  w_ns = S_IDLE;
        endcase
    end

    always_comb begin
        case (r_op_q)
            3'd4:       w_cls = 2'b11;
            3'd5:       w_cls = 2'b10;
            3'd6, 3'd7: w_cls = 2'b00;
            default:    w_cls = 2'b01;
        endcase
    end

    always_comb begin
        o_x_en    = 1'b0;
        o_y_en    = 1'b0;
        o_f_en    = 1'b0;
        o_hi_en   = 1'b0;
        o_lo_en   = 1'b0;
        o_sel_hi  = 2'b00;
        o_sel_lo  = 2'b00;
        o_op_calc = 2'b00;
        o_sel_p   = 1'b0;
        o_go_calc = 1'b0;
        o_go_div  = 1'b0;
        o_done    = 1'b0;
        o_busy    = (r_cs != S_IDLE);
        o_err     = r_err;
        o_cs      = r_cs;
        case (r_cs)
            S_LOAD: begin
                o_x_en = 1'b1;
                o_y_en = 1'b1;
                o_f_en = 1'b1;
            end
            S_DECODE: o_sel_p = (r_op_q[2:1] == 2'b11) ? r_op_q[0] : 1'b0;
            S_CGO: begin
                o_go_calc = 1'b1;
                o_op_calc = r_op_q[1:0];
                o_sel_lo  = 2'b01;
            end
            S_CWAIT: begin
                o_go_calc = 1'b1;
                o_op_calc = r_op_q[1:0];
                o_sel_hi  = 2'b01;
                o_sel_lo  = 2'b01;
            end
            S_MWAIT: begin
                o_sel_hi = 2'b10;
                o_sel_lo = 2'b10;
            end
            S_DIVGO: begin
                o_go_div = 1'b1;
                o_sel_lo = 2'b11;
            end
            S_DWAIT: begin
                o_go_div = 1'b1;
                o_sel_hi = 2'b11;
                o_sel_lo = 2'b11;
            end
            S_DONE: begin
                o_hi_en  = 1'b1;
                o_lo_en  = 1'b1;
                o_done   = 1'b1;
                o_sel_hi = w_cls;
                o_sel_lo = w_cls;
                o_sel_p  = (r_op_q[2:1] == 2'b11) ? r_op_q[0] : 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_calc_ctrl_unit_p.sv
// Bench for calc_ctrl_unit_p: two builds (MUL_LAT 3 and 1, TIMEOUT 8) share stimulus;
// expected completion/error events are queued per build and checked by monitors.
module tb_calc_ctrl_unit_p;

    typedef struct packed {
        logic       is_err;
        logic [7:0] idx;
        logic [1:0] sh;
        logic [1:0] sl;
        logic       sp;
        logic [1:0] err;
        logic [1:0] en;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go = 1'b0;
    logic [2:0] op_code = 3'd0;
    logic       y_zero = 1'b0;
    logic       done_calc = 1'b0;
    logic       done_div = 1'b0;

    logic       x_en_a, y_en_a, f_en_a, hi_en_a, lo_en_a, sel_p_a, go_calc_a, go_div_a, busy_a, done_a;
    logic [1:0] sel_hi_a, sel_lo_a, op_calc_a, err_a;
    logic [3:0] cs_a;
    logic       x_en_b, y_en_b, f_en_b, hi_en_b, lo_en_b, sel_p_b, go_calc_b, go_div_b, busy_b, done_b;
    logic [1:0] sel_hi_b, sel_lo_b, op_calc_b, err_b;
    logic [3:0] cs_b;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_a = 0;
    int   start_b = 0;
    logic [1:0] exp_calc = 2'b00;
    ev_t  qa[$];
    ev_t  qb[$];

    calc_ctrl_unit_p #(.MUL_LAT(3), .TIMEOUT(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_go(go), .i_op_code(op_code), .i_y_zero(y_zero),
        .i_done_calc(done_calc), .i_done_div(done_div),
        .o_x_en(x_en_a), .o_y_en(y_en_a), .o_f_en(f_en_a), .o_hi_en(hi_en_a), .o_lo_en(lo_en_a),
        .o_sel_hi(sel_hi_a), .o_sel_lo(sel_lo_a), .o_op_calc(op_calc_a), .o_sel_p(sel_p_a),
        .o_go_calc(go_calc_a), .o_go_div(go_div_a), .o_busy(busy_a), .o_done(done_a),
        .o_err(err_a), .o_cs(cs_a)
    );

    calc_ctrl_unit_p #(.MUL_LAT(1), .TIMEOUT(8)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_go(go), .i_op_code(op_code), .i_y_zero(y_zero),
        .i_done_calc(done_calc), .i_done_div(done_div),
        .o_x_en(x_en_b), .o_y_en(y_en_b), .o_f_en(f_en_b), .o_hi_en(hi_en_b), .o_lo_en(lo_en_b),
        .o_sel_hi(sel_hi_b), .o_sel_lo(sel_lo_b), .o_op_calc(op_calc_b), .o_sel_p(sel_p_b),
        .o_go_calc(go_calc_b), .o_go_div(go_div_b), .o_busy(busy_b), .o_done(done_b),
        .o_err(err_b), .o_cs(cs_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic evt(input int which, input ev_t act);
        ev_t e;
        checks++;
        if (which == 0 && qa.size() > 0)      e = qa.pop_front();
        else if (which == 1 && qb.size() > 0) e = qb.pop_front();
        else begin
            errors++;
            $display("FAIL event dut%0d unexpected: is_err=%0d idx=%0d, want none", which, act.is_err, act.idx);
            return;
        end
        if (act !== e) begin
            errors++;
            $display("FAIL event dut%0d: got is_err=%0d idx=%0d sh=%b sl=%b sp=%b err=%b en=%b, want is_err=%0d idx=%0d sh=%b sl=%b sp=%b err=%b en=%b",
                     which, act.is_err, act.idx, act.sh, act.sl, act.sp, act.err, act.en,
                     e.is_err, e.idx, e.sh, e.sl, e.sp, e.err, e.en);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        if (cs_a == 4'd1) start_a = cyc - 1;
        if (cs_a == 4'd3 || cs_a == 4'd6) check("op_calc", {30'd0, op_calc_a}, {30'd0, exp_calc});
        if (done_a || cs_a == 4'd9)
            evt(0, '{is_err: (cs_a == 4'd9), idx: 8'(cyc - start_a), sh: sel_hi_a, sl: sel_lo_a,
                     sp: sel_p_a, err: err_a, en: {hi_en_a, lo_en_a}});
    end

    always @(negedge clk) if (!rst) begin
        if (cs_b == 4'd1) start_b = cyc - 1;
        if (done_b || cs_b == 4'd9)
            evt(1, '{is_err: (cs_b == 4'd9), idx: 8'(cyc - start_b), sh: sel_hi_b, sl: sel_lo_b,
                     sp: sel_p_b, err: err_b, en: {hi_en_b, lo_en_b}});
    end

    task automatic exp_done(input int ia, input int ib, input logic [1:0] sel, input logic sp);
        qa.push_back('{is_err: 1'b0, idx: 8'(ia), sh: sel, sl: sel, sp: sp, err: 2'b00, en: 2'b11});
        qb.push_back('{is_err: 1'b0, idx: 8'(ib), sh: sel, sl: sel, sp: sp, err: 2'b00, en: 2'b11});
    endtask

    task automatic exp_err(input int idx, input logic [1:0] err);
        ev_t e;
        e = '{is_err: 1'b1, idx: 8'(idx), sh: 2'b00, sl: 2'b00, sp: 1'b0, err: err, en: 2'b00};
        qa.push_back(e);
        qb.push_back(e);
    endtask

    // Returns at the falling edge inside cycle 1 (LOAD).
    task automatic issue(input logic [2:0] op, input logic yz);
        @(negedge clk);
        op_code  = op;
        y_zero   = yz;
        go       = 1'b1;
        exp_calc = op[1:0];
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (20) @(negedge clk);
        check({name, " pending"}, qa.size() + qb.size(), 0);
        qa.delete();
        qb.delete();
    endtask

    initial begin
        #1;
        check("reset outputs a", {x_en_a, y_en_a, f_en_a, hi_en_a, lo_en_a, sel_hi_a, sel_lo_a, op_calc_a,
                                  sel_p_a, go_calc_a, go_div_a, busy_a, done_a, err_a, cs_a}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        exp_done(3, 3, 2'b00, 1'b1);
        issue(3'd7, 1'b0);
        drain("pass b");

        exp_done(3, 3, 2'b00, 1'b0);
        issue(3'd6, 1'b0);
        drain("pass a");

        // ALU op 2, done_calc in cycle 9; op_code and a stray go change mid-run
        exp_done(10, 10, 2'b01, 1'b0);
        issue(3'd2, 1'b0);
        op_code = 3'd5;
        repeat (4) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
        done_calc = 1'b1;
        @(negedge clk);
        done_calc = 1'b0;
        drain("alu");

        exp_done(6, 4, 2'b10, 1'b0);
        issue(3'd5, 1'b0);
        drain("mul");

        exp_err(3, 2'b01);
        issue(3'd4, 1'b1);
        drain("div zero");
        check("err sticky", {30'd0, err_a}, 32'd1);
        check("idle after err", {28'd0, cs_a}, 32'd0);

        exp_done(6, 6, 2'b01, 1'b0);
        issue(3'd0, 1'b1);
        check("err clear on go", {30'd0, err_a}, 32'd0);
        repeat (4) @(negedge clk);
        done_calc = 1'b1;
        @(negedge clk);
        done_calc = 1'b0;
        drain("alu yzero");

        exp_done(7, 7, 2'b11, 1'b0);
        issue(3'd4, 1'b0);
        repeat (5) @(negedge clk);
        done_div = 1'b1;
        @(negedge clk);
        done_div = 1'b0;
        drain("div");

        exp_err(12, 2'b10);
        issue(3'd4, 1'b0);
        drain("div timeout");

        exp_done(12, 12, 2'b11, 1'b0);
        issue(3'd4, 1'b0);
        repeat (10) @(negedge clk);
        done_div = 1'b1;
        @(negedge clk);
        done_div = 1'b0;
        drain("div last cycle");

        // Reset mid-CWAIT, then a fresh pass op
        issue(3'd3, 1'b0);
        repeat (4) @(negedge clk);
        check("in cwait", {28'd0, cs_a}, 32'd6);
        #2 rst = 1'b1;
        #1;
        check("async reset a", {x_en_a, y_en_a, f_en_a, hi_en_a, lo_en_a, sel_hi_a, sel_lo_a, op_calc_a,
                                sel_p_a, go_calc_a, go_div_a, busy_a, done_a, err_a, cs_a}, 0);
        check("async reset b", {x_en_b, y_en_b, f_en_b, hi_en_b, lo_en_b, sel_hi_b, sel_lo_b, op_calc_b,
                                sel_p_b, go_calc_b, go_div_b, busy_b, done_b, err_b, cs_b}, 0);
        @(negedge clk);
        check("held reset cs", {28'd0, cs_a}, 32'd0);
        rst = 1'b0;
        exp_done(3, 3, 2'b00, 1'b1);
        issue(3'd7, 1'b0);
        drain("post reset pass");

        // go held high: restart straight after DONE returns to IDLE
        exp_done(3, 3, 2'b00, 1'b0);
        exp_done(3, 3, 2'b00, 1'b0);
        @(negedge clk);
        op_code = 3'd6;
        go = 1'b1;
        repeat (5) @(negedge clk);
        go = 1'b0;
        drain("go held");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
